// File: rtl/generic_sram_pkg.sv
// Shared encodings and the byte-lane merge helper for the generic byte-write SRAM.
// Imported by the top and by the clear controller.
package generic_sram_pkg;

  localparam int unsigned WRM_THROUGH    = 0;
  localparam int unsigned WRM_READ_FIRST = 1;
  localparam int unsigned WRM_NO_CHANGE  = 2;

  // Widest word the merge helper handles; callers cast to and from this width.
  localparam int unsigned MERGE_W  = 1024;
  localparam int unsigned MERGE_IW = 10;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } sram_state_e;

  // Bit i takes new_word when the lane holding it (i / bw) is enabled.
  function automatic logic [MERGE_W-1:0] byte_merge(input logic [MERGE_W-1:0] old_word,
                                                    input logic [MERGE_W-1:0] new_word,
                                                    input logic [MERGE_W-1:0] be,
                                                    input int unsigned        bw);
    logic [MERGE_W-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < MERGE_W; i++) begin
      if (be[MERGE_IW'(i / bw)]) merged[MERGE_IW'(i)] = new_word[MERGE_IW'(i)];
    end
    return merged;
  endfunction

endpackage

// File: rtl/generic_sram_clr_ctl.sv
// Post-reset clear sequencer: walks every address once writing zero, holding busy meanwhile.
module generic_sram_clr_ctl
  import generic_sram_pkg::*;
#(
  parameter int unsigned AW       = 10,
  parameter int unsigned DD       = 1024,
  parameter int unsigned INIT_CLR = 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  sram_state_e   st_q, st_d;
  logic [AW-1:0] addr_q, addr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= (INIT_CLR != 0) ? ST_CLEAR : ST_READY;
      addr_q <= '0;
    end else begin
      st_q   <= st_d;
      addr_q <= addr_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    addr_d = addr_q;
    clr_we = 1'b0;
    unique case (st_q)
      ST_CLEAR: begin
        // A reset edge must not touch the array, so the clear write is held off.
        clr_we = ~reset;
        if (addr_q == AW'(DD - 1)) begin
          st_d   = ST_READY;
          addr_d = '0;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      ST_READY: st_d = ST_READY;
    endcase
  end

  assign busy     = (st_q == ST_CLEAR);
  assign clr_addr = addr_q;

endmodule

// File: rtl/generic_sram_bw.sv
// Single-port synchronous SRAM with byte write enables, selectable read-during-write
// behaviour, optional output register, post-reset clear and output-enable gating.
module generic_sram_bw
  import generic_sram_pkg::*;
#(
  parameter  int unsigned DW       = 128,
  parameter  int unsigned DD       = 1024,
  parameter  int unsigned AW       = 10,
  parameter  int unsigned BW       = 8,
  parameter  int unsigned OUT_REG  = 0,
  parameter  int unsigned WR_MODE  = 0,
  parameter  int unsigned INIT_CLR = 1,
  localparam int unsigned NB       = DW / BW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          n_cs,
  input  logic          n_we,
  input  logic          n_oe,
  input  logic [NB-1:0] be,
  input  logic [AW-1:0] ad,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          rd_valid,
  output logic          busy
);

  logic          clr_busy, clr_we;
  logic [AW-1:0] clr_addr;

  generic_sram_clr_ctl #(
    .AW      (AW),
    .DD      (DD),
    .INIT_CLR(INIT_CLR)
  ) u_clr_ctl (
    .clk     (clk),
    .reset   (reset),
    .busy    (clr_busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  logic [DW-1:0] mem [DD];
  logic          access, in_range, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] old_word, merged_word, mem_wdata;

  assign access      = ~n_cs & ~clr_busy & ~reset;
  assign in_range    = (32'(ad) < DD);
  assign old_word    = in_range ? mem[ad] : '0;
  assign merged_word = DW'(byte_merge(MERGE_W'(old_word), MERGE_W'(din), MERGE_W'(be), BW));

  // The clear sequencer owns the array port while busy.
  assign mem_we    = clr_we | (access & ~n_we & in_range);
  assign mem_addr  = clr_busy ? clr_addr : ad;
  assign mem_wdata = clr_busy ? '0 : merged_word;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  logic [DW-1:0] d1_q, d1_d;
  logic          v1_q, v1_d;

  always_comb begin
    d1_d = d1_q;
    v1_d = 1'b0;
    if (access) begin
      if (n_we || WR_MODE == WRM_READ_FIRST) begin
        d1_d = old_word;
        v1_d = 1'b1;
      end else if (WR_MODE != WRM_NO_CHANGE) begin
        d1_d = in_range ? merged_word : '0;
        v1_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      d1_q <= d1_d;
      v1_q <= v1_d;
    end
  end

  logic [DW-1:0] data_out;
  logic          valid_out;

  if (OUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] d2_q;
    logic          v2_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        d2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        d2_q <= d1_q;
        v2_q <= v1_q;
      end
    end
    assign data_out  = d2_q;
    assign valid_out = v2_q;
  end else begin : g_no_out_reg
    assign data_out  = d1_q;
    assign valid_out = v1_q;
  end

  assign dout     = n_oe ? '0 : data_out;
  assign rd_valid = valid_out;
  assign busy     = clr_busy;

endmodule

// File: tb/tb_generic_sram_bw.sv
// Five SRAM configurations driven in lockstep and compared every cycle against a
// word-level reference model, plus directed constant checks.
module tb_generic_sram_bw;

  localparam int NI = 5;

  logic        clk = 1'b0;
  logic        reset, n_cs, n_we, n_oe;
  logic [3:0]  be;
  logic [3:0]  ad;
  logic [31:0] din;

  logic [31:0] dout_w [NI];
  logic        rdv_w  [NI];
  logic        busy_w [NI];

  always #5 clk = ~clk;

  // 0: through  1: read-first  2: no-change  3: through+out reg  4: through, DD=12
  for (genvar g = 0; g < NI; g++) begin : g_dut
    generic_sram_bw #(
      .DW      (32),
      .DD      ((g == 4) ? 12 : 16),
      .AW      (4),
      .BW      (8),
      .OUT_REG ((g == 3) ? 1 : 0),
      .WR_MODE ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
      .INIT_CLR(1)
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .n_cs    (n_cs),
      .n_we    (n_we),
      .n_oe    (n_oe),
      .be      (be),
      .ad      (ad),
      .din     (din),
      .dout    (dout_w[g]),
      .rd_valid(rdv_w[g]),
      .busy    (busy_w[g])
    );
  end

  int m_dd   [NI] = '{16, 16, 16, 16, 12};
  int m_mode [NI] = '{0, 1, 2, 0, 0};
  int m_oreg [NI] = '{0, 0, 0, 1, 0};

  logic [31:0] mm  [NI][16];
  logic [31:0] s1d [NI];
  logic [31:0] s2d [NI];
  logic        s1v [NI];
  logic        s2v [NI];
  int          clr_left [NI];
  bit          mdl_ready = 1'b0;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic model_edge(input logic rst, input logic cs_n, input logic we_n,
                            input logic [3:0] b, input logic [3:0] a, input logic [31:0] d);
    logic [31:0] old_w, new_w;
    bit          inr;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        s1d[k] = '0; s1v[k] = 1'b0; s2d[k] = '0; s2v[k] = 1'b0;
        clr_left[k] = m_dd[k];
      end else begin
        s2d[k] = s1d[k];
        s2v[k] = s1v[k];
        s1v[k] = 1'b0;
        if (clr_left[k] > 0) begin
          mm[k][m_dd[k] - clr_left[k]] = '0;
          clr_left[k]--;
        end else if (!cs_n) begin
          inr   = (int'(a) < m_dd[k]);
          old_w = inr ? mm[k][a] : 32'h0;
          if (we_n) begin
            s1d[k] = old_w; s1v[k] = 1'b1;
          end else begin
            new_w = old_w;
            for (int l = 0; l < 4; l++) if (b[l]) new_w[l*8 +: 8] = d[l*8 +: 8];
            if (inr) mm[k][a] = new_w;
            if (m_mode[k] == 0) begin
              s1d[k] = inr ? new_w : 32'h0; s1v[k] = 1'b1;
            end else if (m_mode[k] == 1) begin
              s1d[k] = old_w; s1v[k] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic cs_n, input logic we_n, input logic oe_n,
                      input logic [3:0] b, input logic [3:0] a, input logic [31:0] d);
    logic [31:0] e_d;
    logic        e_v;
    reset = rst; n_cs = cs_n; n_we = we_n; n_oe = oe_n; be = b; ad = a; din = d;
    @(posedge clk);
    model_edge(rst, cs_n, we_n, b, a, d);
    if (rst) mdl_ready = 1'b1;
    #1;
    if (mdl_ready) begin
      for (int k = 0; k < NI; k++) begin
        e_d = (m_oreg[k] != 0) ? s2d[k] : s1d[k];
        e_v = (m_oreg[k] != 0) ? s2v[k] : s1v[k];
        chk($sformatf("dout[%0d]", k), dout_w[k], oe_n ? 32'h0 : e_d);
        chk($sformatf("rd_valid[%0d]", k), 32'(rdv_w[k]), 32'(e_v));
        chk($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(clr_left[k] > 0));
      end
    end
  endtask

  initial begin
    int cnt, c4;
    step(1, 1, 1, 0, 4'h0, 4'h0, 32'h0);
    chk("reset_busy", 32'(busy_w[0]), 32'h1);
    chk("reset_dout", dout_w[0], 32'h0);

    // Clear interrupted by reset at cycle 5; user writes during busy must be ignored.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 4'hF, 4'h0, 32'hDEAD0000);
    step(1, 0, 0, 0, 4'hF, 4'h0, 32'hDEAD0000);
    cnt = 0; c4 = 0;
    while (busy_w[0] && cnt < 40) begin
      if (busy_w[4]) c4++;
      step(0, (cnt >= 12) ? 1'b1 : 1'b0, 0, 0, 4'hF, 4'h0, 32'hDEAD0000);
      cnt++;
    end
    chk("busy_len_dd16", 32'(cnt), 32'd16);
    chk("busy_len_dd12", 32'(c4), 32'd12);

    for (int a = 0; a < 16; a++) begin
      step(0, 0, 1, 0, 4'h0, 4'(a), 32'h0);
      chk("clear_read", dout_w[0], 32'h0);
      chk("clear_read_valid", 32'(rdv_w[0]), 32'h1);
    end

    // Byte-lane merge and read-during-write modes
    step(0, 0, 0, 0, 4'hF, 4'd3, 32'hAABBCCDD);
    step(0, 0, 0, 0, 4'h5, 4'd3, 32'h11223344);
    chk("merge_through", dout_w[0], 32'hAA22CC44);
    chk("merge_read_first", dout_w[1], 32'hAABBCCDD);
    chk("no_change_valid", 32'(rdv_w[2]), 32'h0);
    step(0, 0, 1, 0, 4'h0, 4'd3, 32'h0);
    chk("merge_readback", dout_w[0], 32'hAA22CC44);
    step(0, 0, 0, 0, 4'hF, 4'd5, 32'h1234);
    step(0, 0, 0, 0, 4'hF, 4'd5, 32'h5678);
    chk("read_first_old", dout_w[1], 32'h1234);
    chk("no_change_hold", dout_w[2], 32'hAA22CC44);

    // Output register latency and back-to-back reads
    step(0, 0, 0, 0, 4'hF, 4'd7, 32'hCAFE);
    step(0, 0, 0, 0, 4'hF, 4'd8, 32'hBEEF);
    step(0, 1, 1, 0, 4'h0, 4'd0, 32'h0);
    step(0, 0, 1, 0, 4'h0, 4'd7, 32'h0);
    chk("oreg_edge_n_valid", 32'(rdv_w[3]), 32'h0);
    step(0, 0, 1, 0, 4'h0, 4'd8, 32'h0);
    chk("oreg_n1_data", dout_w[3], 32'hCAFE);
    chk("oreg_n1_valid", 32'(rdv_w[3]), 32'h1);
    step(0, 1, 1, 0, 4'h0, 4'd0, 32'h0);
    chk("oreg_b2b_data", dout_w[3], 32'hBEEF);
    chk("oreg_b2b_valid", 32'(rdv_w[3]), 32'h1);

    // Out-of-range access and output-enable gating on the DD=12 instance
    step(0, 0, 0, 0, 4'hF, 4'd11, 32'h11);
    step(0, 0, 0, 0, 4'hF, 4'd13, 32'hFF);
    step(0, 0, 1, 0, 4'h0, 4'd13, 32'h0);
    chk("oor_read_data", dout_w[4], 32'h0);
    chk("oor_read_valid", 32'(rdv_w[4]), 32'h1);
    step(0, 0, 1, 1, 4'h0, 4'd11, 32'h0);
    chk("oe_gated_data", dout_w[4], 32'h0);
    chk("oe_gated_valid", 32'(rdv_w[4]), 32'h1);
    step(0, 1, 1, 0, 4'h0, 4'd0, 32'h0);
    chk("oe_held_data", dout_w[4], 32'h11);

    // Randomized traffic, with an occasional reset
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)),
           $urandom);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
